// File: rtl/data_check_pkg.sv
// Shared definitions for the PAM4 receive frame synchroniser / PRBS checker.
package data_check_pkg;

  typedef enum logic [1:0] {
    ST_HUNT  = 2'd0,
    ST_HEAD  = 2'd1,
    ST_PRIME = 2'd2,
    ST_CHECK = 2'd3
  } state_t;

  localparam int         HEAD_LEN = 6;
  localparam logic [1:0] HEAD_HI  = 2'd3;
  localparam logic [1:0] HEAD_LO  = 2'd0;

  // Symbols needed to fill an N-bit history at two bits per symbol.
  function automatic int prime_len(input int n);
    return (n + 1) / 2;
  endfunction

  // Header symbol expected at position idx: HI on even positions, LO on odd.
  function automatic logic [1:0] head_sym(input logic [2:0] idx);
    return idx[0] ? HEAD_LO : HEAD_HI;
  endfunction

endpackage

// File: rtl/data_check_if.sv
// Symbol stream, control and measurement bundle for data_check.
interface data_check_if #(
  parameter int CNT_WIDTH = 32
);
  logic [1:0]           data_in;
  logic                 check_enable;
  logic                 check_clear;
  logic                 locked;
  logic                 err_flag;
  logic [CNT_WIDTH-1:0] err_cnt;
  logic [CNT_WIDTH-1:0] sym_cnt;

  modport master (
    output data_in, check_enable, check_clear,
    input  locked, err_flag, err_cnt, sym_cnt
  );

  modport slave (
    input  data_in, check_enable, check_clear,
    output locked, err_flag, err_cnt, sym_cnt
  );
endinterface

// File: rtl/data_check_prbs_chk_slice.sv
// Two-bit self-synchronising PRBS check over an N-bit received-bit history.
// hist[0] holds the newest bit, so hist[K-1] is the bit K positions back.
module prbs_chk_slice #(
  parameter int N   = 9,
  parameter int T   = 5,
  parameter bit INV = 1'b1
) (
  input  logic [N-1:0] hist,
  input  logic [1:0]   sym,
  output logic [1:0]   err,
  output logic [N-1:0] hist_next
);
  logic [N-1:0] hist_mid;

  // Earlier bit first; the later bit sees history that already holds it.
  always_comb begin
    err[1]    = sym[1] ^ (hist[N-1] ^ hist[T-1] ^ INV);
    hist_mid  = {hist[N-2:0], sym[1]};
    err[0]    = sym[0] ^ (hist_mid[N-1] ^ hist_mid[T-1] ^ INV);
    hist_next = {hist_mid[N-2:0], sym[0]};
  end
endmodule

// File: rtl/data_check.sv
// Frame header hunt (3,0,3,0,3,0), PRBS history priming, then bit-error and
// checked-symbol counting for BER measurement on the received PAM4 stream.
module data_check
  import data_check_pkg::*;
#(
  parameter int INV_PATTERN = 1,
  parameter int POLY_LENGHT = 9,
  parameter int POLY_TAP    = 5,
  parameter int CNT_WIDTH   = 32
) (
  input  logic         clk,
  input  logic         rst_n,
  data_check_if.slave  bus
);
  localparam int PRIME_LEN = prime_len(POLY_LENGHT);
  localparam int PW        = $clog2(PRIME_LEN + 1);

  state_t                 state, state_nx;
  logic [2:0]             idx, idx_nx;
  logic [PW-1:0]          pcnt, pcnt_nx;
  logic [POLY_LENGHT-1:0] hist, hist_nx;
  logic [1:0]             sym_err;
  logic [1:0]             err_sum;

  function automatic logic [CNT_WIDTH-1:0] sat_add(input logic [CNT_WIDTH-1:0] a,
                                                   input logic [1:0] b);
    logic [CNT_WIDTH:0] s;
    s = {1'b0, a} + {{(CNT_WIDTH-1){1'b0}}, b};
    return s[CNT_WIDTH] ? '1 : s[CNT_WIDTH-1:0];
  endfunction

  prbs_chk_slice #(
    .N   (POLY_LENGHT),
    .T   (POLY_TAP),
    .INV (INV_PATTERN != 0)
  ) u_slice (
    .hist      (hist),
    .sym       (bus.data_in),
    .err       (sym_err),
    .hist_next (hist_nx)
  );

  assign err_sum = {1'b0, sym_err[1]} + {1'b0, sym_err[0]};

  // Next-state logic: header matching restarts at idx 1 on a stray HI symbol.
  always_comb begin
    state_nx = state;
    idx_nx   = idx;
    pcnt_nx  = pcnt;
    if (!bus.check_enable) begin
      state_nx = ST_HUNT;
      idx_nx   = '0;
      pcnt_nx  = '0;
    end else begin
      case (state)
        ST_HUNT: begin
          if (bus.data_in == HEAD_HI) begin
            state_nx = ST_HEAD;
            idx_nx   = 3'd1;
          end
        end
        ST_HEAD: begin
          if (bus.data_in == head_sym(idx)) begin
            if (idx == 3'(HEAD_LEN - 1)) begin
              state_nx = ST_PRIME;
              idx_nx   = '0;
              pcnt_nx  = '0;
            end else begin
              idx_nx = idx + 3'd1;
            end
          end else if (bus.data_in == HEAD_HI) begin
            idx_nx = 3'd1;
          end else begin
            state_nx = ST_HUNT;
            idx_nx   = '0;
          end
        end
        ST_PRIME: begin
          if (pcnt == PW'(PRIME_LEN - 1)) begin
            state_nx = ST_CHECK;
            pcnt_nx  = '0;
          end else begin
            pcnt_nx = pcnt + PW'(1);
          end
        end
        default: ;
      endcase
    end
  end

  // Control state register; locked mirrors entry into CHECK.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= ST_HUNT;
      idx        <= '0;
      pcnt       <= '0;
      bus.locked <= 1'b0;
    end else begin
      state      <= state_nx;
      idx        <= idx_nx;
      pcnt       <= pcnt_nx;
      bus.locked <= (state_nx == ST_CHECK);
    end
  end

  // History shifts on received bits during PRIME and CHECK; counters
  // update only for symbols sampled in CHECK, with clear taking priority.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hist         <= '0;
      bus.err_flag <= 1'b0;
      bus.err_cnt  <= '0;
      bus.sym_cnt  <= '0;
    end else begin
      if (state == ST_PRIME || state == ST_CHECK) hist <= hist_nx;
      bus.err_flag <= (state == ST_CHECK) && (|sym_err);
      if (bus.check_clear) begin
        bus.err_cnt <= '0;
        bus.sym_cnt <= '0;
      end else if (state == ST_CHECK) begin
        bus.err_cnt <= sat_add(bus.err_cnt, err_sum);
        bus.sym_cnt <= sat_add(bus.sym_cnt, 2'd1);
      end
    end
  end
endmodule

// File: tb/tb_data_check.sv
// Directed bench for data_check: lock, clean PRBS9, single-bit errors,
// clear, counter saturation, false header and mid-run reset.
module tb_data_check;
  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  data_check_if #(.CNT_WIDTH(32)) bus ();
  data_check_if #(.CNT_WIDTH(4))  bus4 ();

  assign bus4.data_in      = bus.data_in;
  assign bus4.check_enable = bus.check_enable;
  assign bus4.check_clear  = bus.check_clear;

  data_check #(.INV_PATTERN(1), .POLY_LENGHT(9), .POLY_TAP(5), .CNT_WIDTH(32)) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus));
  data_check #(.INV_PATTERN(1), .POLY_LENGHT(9), .POLY_TAP(5), .CNT_WIDTH(4)) dut4 (
    .clk(clk), .rst_n(rst_n), .bus(bus4));

  int n_checks = 0;
  int n_fail   = 0;
  logic [8:0] g;

  // Inverted PRBS9 transmitter model: raw[n] = raw[n-9] ^ raw[n-5].
  task gen_sym(output logic [1:0] s);
    logic raw;
    for (int i = 1; i >= 0; i--) begin
      raw  = g[8] ^ g[4];
      g    = {g[7:0], raw};
      s[i] = ~raw;
    end
  endtask

  task step(input logic [1:0] s);
    bus.data_in = s;
    @(posedge clk);
    #1;
  endtask

  task send_clean(input int n);
    logic [1:0] s;
    for (int i = 0; i < n; i++) begin
      gen_sym(s);
      step(s);
    end
  endtask

  task send_flipped();
    logic [1:0] s;
    gen_sym(s);
    step(s ^ 2'b10);
  endtask

  task send_header();
    for (int i = 0; i < 6; i++) step((i % 2 == 0) ? 2'd3 : 2'd0);
  endtask

  task test_reset();
    rst_n = 1'b0;
    bus.data_in = 2'd3;
    bus.check_enable = 1'b1;
    bus.check_clear = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    n_checks++;
    if (bus.locked !== 1'b0) begin n_fail++; $display("FAIL reset_locked got %0d want 0", bus.locked); end
    n_checks++;
    if (bus.err_flag !== 1'b0) begin n_fail++; $display("FAIL reset_err_flag got %0d want 0", bus.err_flag); end
    n_checks++;
    if (bus.err_cnt !== 32'd0 || bus.sym_cnt !== 32'd0) begin
      n_fail++; $display("FAIL reset_counters got err=%0d sym=%0d want 0/0", bus.err_cnt, bus.sym_cnt);
    end
    bus.check_enable = 1'b0;
    bus.data_in = 2'd0;
    rst_n = 1'b1;
    step(2'd0);
  endtask

  task test_lock_clean();
    bus.check_enable = 1'b1;
    repeat (4) step(2'd0);
    send_header();
    n_checks++;
    if (bus.locked !== 1'b0) begin n_fail++; $display("FAIL lock_after_header got %0d want 0", bus.locked); end
    g = 9'h1FF;
    send_clean(4);
    n_checks++;
    if (bus.locked !== 1'b0) begin n_fail++; $display("FAIL lock_early got %0d want 0", bus.locked); end
    send_clean(1);
    n_checks++;
    if (bus.locked !== 1'b1 || bus.sym_cnt !== 32'd0) begin
      n_fail++; $display("FAIL lock_at_plus6 got locked=%0d sym=%0d want 1/0", bus.locked, bus.sym_cnt);
    end
    send_clean(511);
    n_checks++;
    if (bus.err_cnt !== 32'd0) begin n_fail++; $display("FAIL clean_err_cnt got %0d want 0", bus.err_cnt); end
    n_checks++;
    if (bus.sym_cnt !== 32'd511) begin n_fail++; $display("FAIL clean_sym_cnt got %0d want 511", bus.sym_cnt); end
    n_checks++;
    if (bus4.sym_cnt !== 4'd15 || bus4.err_cnt !== 4'd0) begin
      n_fail++; $display("FAIL clean_narrow got sym=%0d err=%0d want 15/0", bus4.sym_cnt, bus4.err_cnt);
    end
  endtask

  task test_bit_flip();
    int flags;
    flags = 0;
    send_flipped();
    n_checks++;
    if (bus.err_flag !== 1'b1) begin n_fail++; $display("FAIL flip_flag_now got %0d want 1", bus.err_flag); end
    if (bus.err_flag) flags++;
    for (int i = 0; i < 12; i++) begin
      send_clean(1);
      if (bus.err_flag) flags++;
    end
    n_checks++;
    if (bus.err_cnt !== 32'd3) begin n_fail++; $display("FAIL flip_err_cnt got %0d want 3", bus.err_cnt); end
    n_checks++;
    if (flags != 3) begin n_fail++; $display("FAIL flip_flag_cycles got %0d want 3", flags); end
  endtask

  task test_clear();
    bus.check_clear = 1'b1;
    send_flipped();
    bus.check_clear = 1'b0;
    n_checks++;
    if (bus.err_cnt !== 32'd0 || bus.sym_cnt !== 32'd0) begin
      n_fail++; $display("FAIL clear_counters got err=%0d sym=%0d want 0/0", bus.err_cnt, bus.sym_cnt);
    end
    n_checks++;
    if (bus.locked !== 1'b1) begin n_fail++; $display("FAIL clear_locked got %0d want 1", bus.locked); end
    send_clean(10);
    n_checks++;
    if (bus.err_cnt !== 32'd2 || bus.sym_cnt !== 32'd10) begin
      n_fail++; $display("FAIL clear_after got err=%0d sym=%0d want 2/10", bus.err_cnt, bus.sym_cnt);
    end
  endtask

  task test_saturation();
    for (int i = 0; i < 4; i++) begin
      send_flipped();
      send_clean(10);
    end
    n_checks++;
    if (bus4.err_cnt !== 4'd14 || bus.err_cnt !== 32'd14) begin
      n_fail++; $display("FAIL sat_pre got narrow=%0d wide=%0d want 14/14", bus4.err_cnt, bus.err_cnt);
    end
    send_flipped();
    send_clean(10);
    n_checks++;
    if (bus4.err_cnt !== 4'd15 || bus.err_cnt !== 32'd17) begin
      n_fail++; $display("FAIL sat_cross got narrow=%0d wide=%0d want 15/17", bus4.err_cnt, bus.err_cnt);
    end
    send_flipped();
    send_clean(10);
    n_checks++;
    if (bus4.err_cnt !== 4'd15 || bus.err_cnt !== 32'd20) begin
      n_fail++; $display("FAIL sat_hold got narrow=%0d wide=%0d want 15/20", bus4.err_cnt, bus.err_cnt);
    end
    n_checks++;
    if (bus4.sym_cnt !== 4'd15 || bus.sym_cnt !== 32'd76) begin
      n_fail++; $display("FAIL sat_sym got narrow=%0d wide=%0d want 15/76", bus4.sym_cnt, bus.sym_cnt);
    end
  endtask

  task test_false_header();
    logic [1:0] s;
    logic [1:0] hdr [9];
    hdr = '{2'd3, 2'd0, 2'd3, 2'd3, 2'd0, 2'd3, 2'd0, 2'd3, 2'd0};
    gen_sym(s);
    bus.check_enable = 1'b0;
    step(s);
    n_checks++;
    if (bus.locked !== 1'b0 || bus.sym_cnt !== 32'd77) begin
      n_fail++; $display("FAIL disable_exit got locked=%0d sym=%0d want 0/77", bus.locked, bus.sym_cnt);
    end
    step(2'd0);
    n_checks++;
    if (bus.sym_cnt !== 32'd77 || bus.err_cnt !== 32'd20) begin
      n_fail++; $display("FAIL disable_hold got sym=%0d err=%0d want 77/20", bus.sym_cnt, bus.err_cnt);
    end
    bus.check_clear = 1'b1;
    step(2'd0);
    bus.check_clear = 1'b0;
    bus.check_enable = 1'b1;
    step(2'd0);
    step(2'd0);
    for (int i = 0; i < 9; i++) step(hdr[i]);
    g = 9'h0A5;
    send_clean(4);
    n_checks++;
    if (bus.locked !== 1'b0) begin n_fail++; $display("FAIL false_hdr_early got %0d want 0", bus.locked); end
    send_clean(1);
    n_checks++;
    if (bus.locked !== 1'b1) begin n_fail++; $display("FAIL false_hdr_lock got %0d want 1", bus.locked); end
    send_clean(100);
    n_checks++;
    if (bus.err_cnt !== 32'd0 || bus.sym_cnt !== 32'd100) begin
      n_fail++; $display("FAIL false_hdr_count got err=%0d sym=%0d want 0/100", bus.err_cnt, bus.sym_cnt);
    end
  endtask

  task test_reset_mid();
    send_flipped();
    n_checks++;
    if (bus.err_flag !== 1'b1) begin n_fail++; $display("FAIL pre_reset_flag got %0d want 1", bus.err_flag); end
    #1 rst_n = 1'b0;
    #1;
    n_checks++;
    if (bus.locked !== 1'b0 || bus.err_flag !== 1'b0 || bus.err_cnt !== 32'd0 || bus.sym_cnt !== 32'd0) begin
      n_fail++; $display("FAIL async_reset got locked=%0d flag=%0d err=%0d sym=%0d want all 0",
                         bus.locked, bus.err_flag, bus.err_cnt, bus.sym_cnt);
    end
    @(posedge clk);
    #1 rst_n = 1'b1;
    step(2'd0);
    send_header();
    g = 9'h133;
    send_clean(5);
    n_checks++;
    if (bus.locked !== 1'b1) begin n_fail++; $display("FAIL relock got %0d want 1", bus.locked); end
    send_clean(20);
    n_checks++;
    if (bus.err_cnt !== 32'd0 || bus.sym_cnt !== 32'd20) begin
      n_fail++; $display("FAIL relock_count got err=%0d sym=%0d want 0/20", bus.err_cnt, bus.sym_cnt);
    end
  endtask

  initial begin
    test_reset();
    test_lock_clean();
    test_bit_flip();
    test_clear();
    test_saturation();
    test_false_header();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/data_check.md
# data_check

Receive-side frame synchroniser and PRBS error counter for the PAM4 link. It consumes the 2-bit symbol stream produced by the transmit pattern generator after the RGB/PAM4 channel. It hunts for the 6-symbol frame header (3,0,3,0,3,0), primes a self-synchronising PRBS checker, then counts bit errors and checked symbols for BER measurement.

## Interface
- INV_PATTERN, 1, transmitted PRBS is bit-inverted (must match transmitter)
- POLY_LENGHT, 9, PRBS polynomial length N (x^N + x^T + 1)
- POLY_TAP, 5, PRBS polynomial tap T
- CNT_WIDTH, 32, width of err_cnt and sym_cnt
- clk  input  1  symbol clock, one symbol per cycle
- rst_n  input  1  asynchronous active-low reset
- data_in  input  2  received PAM4 symbol
- check_enable  input  1  level; 1 = hunt/check, 0 = return to HUNT
- check_clear  input  1  pulse; zero err_cnt and sym_cnt
- locked  output  1  header found, checker in CHECK
- err_flag  output  1  registered; ≥1 bit error in the previous checked symbol
- err_cnt  output  CNT_WIDTH  accumulated bit errors, saturating
- sym_cnt  output  CNT_WIDTH  accumulated checked symbols, saturating

## Operation
- Serial bit order: data_in[1] is the earlier bit, data_in[0] the later bit.
- States: HUNT, HEAD, PRIME, CHECK. Reset and check_enable=0 force HUNT.
- HUNT: when data_in==3, go to HEAD with idx=1.
- HEAD: expects 3 at even idx and 0 at odd idx. A match at idx 5 goes to PRIME. Any other match increments idx.
- HEAD mismatch: if data_in==3, stay in HEAD with idx=1; otherwise go to HUNT.
- PRIME: shift both bits into the history register, r[N-1:0]. After ceil(N/2) symbols (5 for N=9), go to CHECK. No checking or counting occurs in PRIME.
- CHECK: each bit is checked in serial order. Expected bit e = r[N-1] ^ r[T-1] (taps N and T back), inverted if INV_PATTERN.
  - A bit error occurs when the received bit != e.
  - The received bit, not e, is then shifted into r.
  - The second bit of a symbol uses history that already includes the first bit.
- Each CHECK cycle: sym_cnt += 1; err_cnt += errors in that symbol (0..2).
- Counters saturate at all-ones. They hold their value outside CHECK and on leaving CHECK.
- check_clear zeroes both counters and takes priority over a same-cycle increment. It does not affect state or locked.
- No automatic loss-of-lock: the block stays in CHECK until check_enable falls or reset.

## Timing
- All outputs are registered. Reset values: locked=0, err_flag=0, err_cnt=0, sym_cnt=0, state=HUNT, idx=0, r=0.
- Header symbols arrive on cycles k..k+5. PRIME covers k+6..k+10 for N=9. The first checked symbol is at cycle k+11.
- locked=1 is visible in the cycle after the final PRIME symbol is sampled, i.e. coincident with the first CHECK cycle.
- err_flag and counter updates for the symbol sampled in cycle c are visible at cycle c+1.
- check_enable falling in cycle c: state=HUNT and locked=0 at c+1. The symbol at c is still counted if the state was CHECK.
- rst_n assertion mid-operation clears all state and outputs immediately (asynchronous). Release is synchronous to the clk edge.

## Structure
- Shared package: state encodings, HEAD_LEN=6, HEAD_HI=2'd3, HEAD_LO=2'd0, and the prime length function ceil(N/2).
- One sub-module, prbs_chk_slice: combinational 2-bit self-synchronising check of N-bit history.
  - Outputs: two error bits and the next history.
  - Parameters: N, T, INV.

## Test plan
- Reset, idle zeros, then header 3,0,3,0,3,0 followed by clean PRBS9 (INV_PATTERN=1) for 511 symbols:
  - locked=1 at header end + 6 cycles.
  - err_cnt=0 and sym_cnt=511 after the last symbol.
- Locked, then flip one bit (data_in[1]) of one PRBS symbol:
  - err_cnt increases by exactly 3 (the flipped bit plus its reuse at taps 5 and 9).
  - err_flag is high on 3 cycles.
- False header 3,0,3,3,0,3,0,3,0 (restart at idx 1 on the repeated 3), then PRBS: locks correctly, err_cnt=0.
- check_clear pulsed on the same cycle as an erroneous symbol: err_cnt=0 and sym_cnt=0 next cycle, locked stays 1.
- Preload err_cnt near all-ones (CNT_WIDTH=4), inject errors: err_cnt saturates at 15.
- rst_n low mid-CHECK: all outputs 0 immediately. After release plus a fresh header, the block relocks.
